// File: rtl/p4_shift_pkg.sv
// Shared definitions for the multi-cycle shifter: op codes, FSM encoding and
// default operand/count widths.
package p4_shift_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_AMT_W = 4;

   localparam logic [1:0] SH_PASS = 2'b00;
   localparam logic [1:0] SH_LSL  = 2'b01;
   localparam logic [1:0] SH_LSR  = 2'b10;
   localparam logic [1:0] SH_ASR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/p4_seq_shifter_if.sv
// Request/result bundle between the datapath controller and the shifter.
interface p4_seq_shifter_if
   import p4_shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int AMT_W = DEF_AMT_W
);

   logic             start;
   logic [WIDTH-1:0] in;
   logic [1:0]       shift;
   logic [AMT_W-1:0] amt;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sout;
   logic             cout;

   modport master (
      output start, in, shift, amt,
      input  busy, done, sout, cout
   );

   modport slave (
      input  start, in, shift, amt,
      output busy, done, sout, cout
   );

endinterface

// File: rtl/p4_shift_step.sv
// Combinational single-bit shift step; reports the bit that falls off the end.
module p4_shift_step
   import p4_shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             bit_out
);

   always_comb begin
      dout    = din;
      bit_out = 1'b0;
      case (op)
         SH_LSL: begin
            dout    = {din[WIDTH-2:0], 1'b0};
            bit_out = din[WIDTH-1];
         end
         SH_LSR: begin
            dout    = {1'b0, din[WIDTH-1:1]};
            bit_out = din[0];
         end
         SH_ASR: begin
            // Sign bit of the working value equals the latched sign bit every step.
            dout    = {din[WIDTH-1], din[WIDTH-1:1]};
            bit_out = din[0];
         end
         default: begin
            dout    = din;
            bit_out = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/p4_seq_shifter.sv
// Multi-cycle variable shifter: one bit per clock, start/busy/done handshake.
module p4_seq_shifter
   import p4_shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int AMT_W = DEF_AMT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   p4_seq_shifter_if.slave  bus
);

   state_t           state_q;
   state_t           state_d;
   logic [1:0]       op_q;
   logic [AMT_W-1:0] count_q;
   logic [WIDTH-1:0] sout_q;
   logic             cout_q;
   logic [WIDTH-1:0] step_out;
   logic             step_bit;
   logic             accept;
   logic             skip;

   // Requests are only honoured when no shift is in flight.
   always_comb begin
      accept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.start;
      skip   = (bus.amt == '0) || (bus.shift == SH_PASS);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               state_d = skip ? ST_DONE : ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (count_q == AMT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   p4_shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .op      (op_q),
      .din     (sout_q),
      .dout    (step_out),
      .bit_out (step_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= SH_PASS;
         count_q <= '0;
         sout_q  <= '0;
         cout_q  <= 1'b0;
      end else if (accept) begin
         op_q    <= bus.shift;
         count_q <= bus.amt;
         sout_q  <= bus.in;
         cout_q  <= 1'b0;
      end else if (state_q == ST_SHIFT) begin
         sout_q  <= step_out;
         cout_q  <= step_bit;
         count_q <= count_q - AMT_W'(1);
      end
   end

   assign bus.busy = (state_q == ST_SHIFT);
   assign bus.done = (state_q == ST_DONE);
   assign bus.sout = sout_q;
   assign bus.cout = cout_q;

endmodule

// File: doc/p4_seq_shifter.md
Name: p4_seq_shifter

Overview:
Multi-cycle, variable-amount shifter for the Simple RISC Machine datapath. It drives a 16-bit operand through 0..15 single-bit shift steps, one per clock, and returns the result and a carry-out. Control uses a start/busy/done handshake. It sits beside the ALU and is sequenced by the datapath controller, which issues a start and waits for done.

Parameters:
WIDTH, 16, operand/result width in bits
AMT_W, 4, shift-amount width; max shift = 2**AMT_W - 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when accepting (IDLE or DONE)
in  input  WIDTH  operand, latched on accepted start
shift  input  2  op: 00 pass, 01 LSL, 10 LSR, 11 ASR (sign fill from bit WIDTH-1); latched on start
amt  input  AMT_W  shift count, latched on start
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse: result valid
sout  output  WIDTH  working/result register; holds after done until next accepted start
cout  output  1  last bit shifted out (LSL: bit WIDTH-1; LSR/ASR: bit 0); 0 for pass or amt=0

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sout=0, cout=0, busy=0, done=0, count=0; effective immediately, including mid-shift; partial result discarded.
- States: IDLE, SHIFT, DONE. busy = (state==SHIFT); done = (state==DONE). Both are registered state decodes, with no combinational path from inputs.
- Accept: start=1 at edge E0 while in IDLE or DONE. Latch op/amt and load sout=in, cout=0.
  - If amt==0 or op==00: go to DONE at E0.
  - Otherwise go to SHIFT with count=amt.
- SHIFT: each edge applies one 1-bit step of the latched op to sout, sets cout to the bit shifted out, and decrements count. At the edge where count goes 1->0, go to DONE.
- Latency: done is high in the cycle following edge E0+amt. For amt=0/pass, done is high in the cycle following E0. busy is high for exactly amt cycles.
- DONE lasts one cycle. If start=0, go to IDLE; if start=1, accept back-to-back as above.
- start while in SHIFT is ignored: no latch, no state change, no error.
- in/shift/amt changes after acceptance have no effect.
- Widths: count is AMT_W bits. amt=15 does 15 steps; there is no wrap. LSL/LSR fill with 0; ASR replicates the latched sign bit each step.
- sout and cout are stable in IDLE and DONE. During SHIFT they show intermediate values, which are not valid.

Decomposition:
- Package p4_shift_pkg:
  - op localparams SH_PASS=2'b00, SH_LSL=2'b01, SH_LSR=2'b10, SH_ASR=2'b11
  - state encoding ST_IDLE, ST_SHIFT, ST_DONE (2-bit)
  - default WIDTH/AMT_W
- Sub-module p4_shift_step: combinational single-bit step (op, WIDTH-bit in -> WIDTH-bit out, shifted-out bit). Instantiated once in the SHIFT datapath.
- Top holds the FSM, counter, and registers.

Test Plan:
- LSL: in=16'h0001, amt=4, start one cycle -> busy high 4 cycles, done 1 cycle later, sout=16'h0010, cout=0.
- LSR: in=16'h8001, amt=1 -> done after 1 shift edge, sout=16'h4000, cout=1. ASR: in=16'h8000, amt=15 -> sout=16'hFFFF, cout=0, busy=15 cycles.
- Pass/zero: shift=00 amt=7 in=16'hABCD, and separately shift=01 amt=0 in=16'hABCD -> busy never high, done next cycle, sout=16'hABCD, cout=0.
- Handshake: start pulsed during SHIFT with different in -> ignored, original result returned. start held high through the DONE cycle with new in=16'h0003 LSL amt=2 -> accepted back-to-back, second done gives 16'h000C.
- Reset mid-op: LSL amt=10, drop rst_n after 3 shifts -> immediately sout=0, cout=0, busy=0, done=0, IDLE. After release, a new start runs normally.
- Hold: after done, change in/shift/amt with start=0 for 5 cycles -> sout/cout unchanged, done stays 0.
